// File: rtl/fir_pkg.sv
// Shared definitions for the Vedic-multiplier FIR chain: sample widths and
// small constant/arithmetic helpers used by the filter and its downstream stages.
package fir_pkg;
  localparam int FIR_IN_W  = 4;
  localparam int FIR_OUT_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Clamp a signed value into the range of a w-bit signed number.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Pointer-based synchronous FIFO; the extra pointer MSB separates full from empty.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            din,
  output logic [W-1:0]            dout,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);
  localparam int AW = clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= din;
        wptr <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: rtl/fir_output_decimator.sv
// Integrate-and-dump decimator behind the FIR: every DEC accepted samples are
// summed, scaled by an arithmetic shift, saturated and queued for a valid/ready consumer.
module fir_output_decimator
  import fir_pkg::*;
#(
  parameter int IN_W       = FIR_OUT_W,
  parameter int OUT_W      = 8,
  parameter int DEC        = 4,
  parameter int SHIFT      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    sat,
  output logic                    overflow
);
  localparam int PH_W  = clog2(DEC);
  localparam int ACC_W = IN_W + PH_W;
  localparam int CW    = clog2(FIFO_DEPTH) + 1;

  logic signed [ACC_W-1:0] acc, sum, scaled;
  logic signed [31:0]      wide, clamped;
  logic [PH_W-1:0]         phase;
  logic [OUT_W-1:0]        fifo_din;
  logic [CW-1:0]           count;
  logic                    dump, pop, full, empty, unused_count;

  assign sum      = acc + $signed({{PH_W{in_data[IN_W-1]}}, in_data});
  assign scaled   = sum >>> SHIFT;
  assign wide     = {{(32-ACC_W){scaled[ACC_W-1]}}, scaled};
  assign clamped  = saturate(wide, OUT_W);
  assign fifo_din = clamped[OUT_W-1:0];
  // flush takes priority, so a sample arriving with flush never dumps
  assign dump     = in_valid && !flush && (phase == PH_W'(DEC - 1));
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign unused_count = ^count;

  sync_fifo #(.W(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (dump),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (out_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      phase    <= '0;
      sat      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (flush || dump) begin
        acc   <= '0;
        phase <= '0;
      end else if (in_valid) begin
        acc   <= sum;
        phase <= phase + PH_W'(1);
      end
      sat <= dump && (clamped != wide);
      if (dump && full && !pop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fir_output_decimator.sv
// Two decimators (SHIFT=2 and SHIFT=0) share one stimulus stream; a frame-level
// reference model queues expected dumps and a monitor checks each handshake.
module tb_fir_output_decimator;
  localparam int DEC   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic signed [7:0] in_data = '0;
  logic [1:0] ov, sat_o, ovf;
  logic [1:0][7:0] od;

  int n_vec = 0, n_err = 0;
  int q0[$], q1[$];
  int fsum[2], fcnt[2], mcnt[2];
  bit esat[2], eovf[2];

  always #5 clk = ~clk;

  fir_output_decimator #(.IN_W(8), .OUT_W(8), .DEC(DEC), .SHIFT(2), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .sat(sat_o[0]), .overflow(ovf[0]));

  fir_output_decimator #(.IN_W(8), .OUT_W(8), .DEC(DEC), .SHIFT(0), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .sat(sat_o[1]), .overflow(ovf[1]));

  task automatic chk(input string name, input int d, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic int divisor(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  // floor(s / dv) with plain integer arithmetic
  function automatic int floor_div(input int s, input int dv);
    int q;
    q = s / dv;
    if ((s % dv) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Reference model: evaluates what the coming rising edge will do.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          chk("rst_out_valid", d, int'(ov[d]), 0);
          chk("rst_out_data", d, int'($signed(od[d])), 0);
          chk("rst_sat", d, int'(sat_o[d]), 0);
          chk("rst_overflow", d, int'(ovf[d]), 0);
          fsum[d] = 0; fcnt[d] = 0; mcnt[d] = 0; esat[d] = 0; eovf[d] = 0;
          if (d == 0) q0.delete(); else q1.delete();
        end else begin
          bit pop;
          chk("out_valid", d, int'(ov[d]), int'(mcnt[d] != 0));
          chk("sat", d, int'(sat_o[d]), int'(esat[d]));
          chk("overflow", d, int'(ovf[d]), int'(eovf[d]));
          esat[d] = 0;
          pop = out_ready && (mcnt[d] != 0);
          if (flush) begin
            fsum[d] = 0; fcnt[d] = 0;
          end else if (in_valid) begin
            fsum[d] += int'(in_data);
            fcnt[d]++;
            if (fcnt[d] == DEC) begin
              int v, c;
              v = floor_div(fsum[d], divisor(d));
              c = clamp8(v);
              esat[d] = (c != v);
              if (mcnt[d] < DEPTH || pop) begin
                if (d == 0) q0.push_back(c); else q1.push_back(c);
                mcnt[d]++;
              end else begin
                eovf[d] = 1;
              end
              fsum[d] = 0; fcnt[d] = 0;
            end
          end
          if (pop) mcnt[d]--;
        end
      end
    end
  end

  // Monitor: every handshake consumes the oldest expected dump.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst_n && ov[d] && out_ready) begin
          int e;
          bit have;
          have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
          if (!have) begin
            chk("unexpected_output", d, 1, 0);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("out_data", d, int'($signed(od[d])), e);
          end
        end
      end
    end
  end

  task automatic step(input bit v, input int data, input bit f, input bit r);
    @(posedge clk);
    #1;
    in_valid = v; in_data = 8'(data); flush = f; out_ready = r;
  endtask

  task automatic send(input int data, input bit r);
    step(1'b1, data, 1'b0, r);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, r);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // averages and floor rounding
    for (int v = 1; v <= 8; v++) send(v, 1'b1);
    idle(3, 1'b1);
    for (int v = 1; v <= 4; v++) send(-v, 1'b1);
    idle(3, 1'b1);

    // saturation on the SHIFT=0 instance
    for (int i = 0; i < 4; i++) send(127, 1'b1);
    for (int i = 0; i < 4; i++) send(-128, 1'b1);
    idle(3, 1'b1);

    // backpressure: fifth dump dropped, then drain
    for (int k = 1; k <= 5; k++)
      for (int i = 0; i < 4; i++) send(k, 1'b0);
    idle(3, 1'b0);
    idle(8, 1'b1);

    // reset mid-frame with a non-empty FIFO
    for (int i = 0; i < 4; i++) send(9, 1'b0);
    send(3, 1'b0);
    send(3, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk("reset_immediate", d, int'(ov[d]), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // full FIFO with a simultaneous pop on the dump edge
    for (int k = 1; k <= 4; k++)
      for (int i = 0; i < 4; i++) send(k, 1'b0);
    for (int i = 0; i < 3; i++) send(6, 1'b0);
    send(6, 1'b1);
    idle(8, 1'b1);

    // flush mid-frame, and flush beating a same-cycle sample
    send(50, 1'b1);
    send(50, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send(1, 1'b1);
    step(1'b1, 99, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send(2, 1'b1);
    idle(3, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128,
           $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0);
    idle(20, 1'b1);

    chk("drained", 0, q0.size(), 0);
    chk("drained", 1, q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
